// File: rtl/ps2_tx_pkg.sv
// Shared PS/2 definitions: transmitter states, keyboard command bytes and
// the microsecond-to-cycle conversion used to size the timers.
package ps2_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        BITS,
        ACK,
        WAITIDLE,
        ERROR
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_ACK        = 8'hFA;

    // Whole cycles per microsecond times the duration.
    function automatic int us_to_cycles(input int clk_hz, input int us);
        return (clk_hz / 1000000) * us;
    endfunction

endpackage

// File: rtl/ps2_tx_line_filter.sv
// ps2_line_filter: 2-FF synchronizer, FILTER_LEN glitch filter and a
// one-cycle falling-edge pulse for a PS/2 clock line. Shared with the receiver.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic fall_o
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Accept a new level only after FILTER_LEN consecutive differing samples.
    always_comb begin
        sync1_d = raw_i;
        sync2_d = sync1_q;
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_d = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Line idles high, so the filter starts at 1 to avoid a false edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device byte transmitter with open-drain enables.
// Optional PS2_TX_RESEND_EN: retry a failed frame twice before reporting
// tx_error, and expose the retry count on attempts.
module ps2_tx
    import ps2_tx_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int INHIBIT_US = 110,
    parameter int TIMEOUT_US = 15000,
    parameter int FILTER_LEN = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
`ifdef PS2_TX_RESEND_EN
    ,
    output logic [1:0] attempts
`endif
);
    localparam int INH = us_to_cycles(CLK_HZ, INHIBIT_US);
    localparam int TMO = us_to_cycles(CLK_HZ, TIMEOUT_US);
    localparam int TW  = $clog2(TMO + 1);

    ps2_state_t    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [9:0]    frame_q, frame_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic          dat_bit_q, dat_bit_d;
    logic          dsync1_q, dsync1_d;
    logic          dsync2_q, dsync2_d;
    logic          clk_lvl, clk_fall, tmo_hit, fail;
`ifdef PS2_TX_RESEND_EN
    logic [7:0]    lat_q, lat_d;
    logic [1:0]    retry_q, retry_d;
`endif

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clock   (clock),
        .reset   (reset),
        .raw_i   (ps2_clk_i),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    // Fires one cycle early so the ERROR cycle lands exactly TMO after restart.
    assign tmo_hit = (timer_q >= TW'(TMO - 1));
    assign busy    = (state_q != IDLE);

    // Next-state, frame shifting and line/handshake outputs.
    always_comb begin
        state_d    = state_q;
        timer_d    = (timer_q == TW'(TMO)) ? timer_q : timer_q + 1'b1;
        frame_d    = frame_q;
        bitcnt_d   = bitcnt_q;
        dat_bit_d  = dat_bit_q;
        dsync1_d   = ps2_dat_i;
        dsync2_d   = dsync1_q;
        fail       = 1'b0;
        tx_ready   = 1'b0;
        tx_done    = 1'b0;
        tx_error   = 1'b0;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
`ifdef PS2_TX_RESEND_EN
        lat_d      = lat_q;
        retry_d    = retry_q;
`endif
        case (state_q)
            IDLE: begin
                tx_ready  = 1'b1;
                dat_bit_d = 1'b0;
                if (tx_valid) begin
                    frame_d = {1'b1, ~^tx_data, tx_data};
                    timer_d = '0;
                    state_d = INHIBIT;
`ifdef PS2_TX_RESEND_EN
                    lat_d   = tx_data;
                    retry_d = '0;
`endif
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (timer_q == TW'(INH - 1)) begin
                    ps2_dat_oe = 1'b1;
                    timer_d    = '0;
                    state_d    = START;
                end
            end
            START: begin
                ps2_dat_oe = 1'b1;
                if (clk_fall) begin
                    dat_bit_d = ~frame_q[0];
                    frame_d   = frame_q >> 1;
                    bitcnt_d  = 4'd1;
                    timer_d   = '0;
                    state_d   = BITS;
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            BITS: begin
                ps2_dat_oe = dat_bit_q;
                if (clk_fall) begin
                    dat_bit_d = ~frame_q[0];
                    frame_d   = frame_q >> 1;
                    bitcnt_d  = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) state_d = ACK;
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    if (!dsync2_q) state_d = WAITIDLE;
                    else           fail    = 1'b1;
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            WAITIDLE: begin
                if (clk_lvl && dsync2_q) begin
                    tx_done = 1'b1;
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            ERROR: begin
                tx_error = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fail) begin
`ifdef PS2_TX_RESEND_EN
            if (retry_q != 2'd2) begin
                retry_d   = retry_q + 2'd1;
                frame_d   = {1'b1, ~^lat_q, lat_q};
                timer_d   = '0;
                dat_bit_d = 1'b0;
                state_d   = INHIBIT;
            end else begin
                state_d = ERROR;
            end
`else
            state_d = ERROR;
`endif
        end
    end

    // State and datapath registers; reset drops both line enables at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            frame_q   <= '0;
            bitcnt_q  <= '0;
            dat_bit_q <= 1'b0;
            dsync1_q  <= 1'b1;
            dsync2_q  <= 1'b1;
`ifdef PS2_TX_RESEND_EN
            lat_q     <= '0;
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            frame_q   <= frame_d;
            bitcnt_q  <= bitcnt_d;
            dat_bit_q <= dat_bit_d;
            dsync1_q  <= dsync1_d;
            dsync2_q  <= dsync2_d;
`ifdef PS2_TX_RESEND_EN
            lat_q     <= lat_d;
            retry_q   <= retry_d;
`endif
        end
    end

`ifdef PS2_TX_RESEND_EN
    assign attempts = retry_q;
`endif

endmodule
